// File: rtl/alu_pkg.sv
// alu_pkg: flag indices, flag width and opcodes shared by the ALU, its result buffer and benches
package alu_pkg;
    localparam int NFLAG         = 4;
    localparam int FLAG_ERR      = 0;
    localparam int FLAG_NEG      = 1;
    localparam int FLAG_POS      = 2;
    localparam int FLAG_OVERFLOW = 3;
    localparam logic [1:0] OP_SUB           = 2'b00;
    localparam logic [1:0] OP_NAND          = 2'b01;
    localparam logic [1:0] OP_STARTING_ONES = 2'b10;
    localparam logic [1:0] OP_DECODE        = 2'b11;
endpackage

// File: rtl/alu_sat_counter.sv
// alu_sat_counter: event counter that sticks at its maximum value, with synchronous clear
module alu_sat_counter #(
    parameter int CNT_W = 8
) (
    input  logic             s_CLK,
    input  logic             s_RSTn,
    input  logic             inc,
    input  logic             clr,
    output logic [CNT_W-1:0] cnt
);
    // clear wins over increment; increment stops at all-ones
    always_ff @(posedge s_CLK or posedge s_RSTn)
        if (s_RSTn) cnt <= '0;
        else if (clr) cnt <= '0;
        else if (inc && !(&cnt)) cnt <= cnt + CNT_W'(1);
endmodule

// File: rtl/alu_result_buffer.sv
// alu_result_buffer: show-ahead FIFO for ALU result/flag pairs with flag statistics and drop indicator
module alu_result_buffer
    import alu_pkg::*;
#(
    parameter int WIDTH = 4,
    parameter int NFLAG = alu_pkg::NFLAG,
    parameter int DEPTH = 4,
    parameter int CNT_W = 8
) (
    input  logic                     s_CLK,
    input  logic                     s_RSTn,
    input  logic                     i_valid,
    input  logic [WIDTH-1:0]         i_result,
    input  logic [NFLAG-1:0]         i_flag,
    output logic                     o_in_ready,
    output logic                     o_valid,
    input  logic                     i_ready,
    output logic [WIDTH-1:0]         o_data,
    output logic [NFLAG-1:0]         o_dflag,
    output logic [$clog2(DEPTH):0]   o_count,
    input  logic                     i_clr_cnt,
    output logic [CNT_W-1:0]         o_err_cnt,
    output logic [CNT_W-1:0]         o_ovf_cnt,
    output logic                     o_drop
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    logic [WIDTH+NFLAG-1:0] mem [DEPTH];
    logic [WIDTH+NFLAG-1:0] head;
    logic [AW-1:0]          wr_ptr, rd_ptr;
    logic [CW-1:0]          count;
    logic                   full, empty, push, pop;
    assign full       = count == CW'(DEPTH);
    assign empty      = count == '0;
    assign push       = i_valid & ~full;
    assign pop        = ~empty & i_ready;
    assign head       = mem[rd_ptr];
    assign o_in_ready = ~full;
    assign o_valid    = ~empty;
    assign o_count    = count;
    assign o_data     = empty ? '0 : head[NFLAG +: WIDTH];
    assign o_dflag    = empty ? '0 : head[NFLAG-1:0];
    // storage is not reset; empty masking hides stale entries
    always_ff @(posedge s_CLK)
        if (push) mem[wr_ptr] <= {i_result, i_flag};
    // pointers wrap naturally since DEPTH is a power of two; occupancy tracks push/pop exactly
    always_ff @(posedge s_CLK or posedge s_RSTn)
        if (s_RSTn) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + AW'(1);
            if (pop) rd_ptr <= rd_ptr + AW'(1);
            count <= count + CW'(push) - CW'(pop);
        end
    // sticky loss flag: set on a result offered while full, clear has priority
    always_ff @(posedge s_CLK or posedge s_RSTn)
        if (s_RSTn) o_drop <= 1'b0;
        else if (i_clr_cnt) o_drop <= 1'b0;
        else if (i_valid && full) o_drop <= 1'b1;
    alu_sat_counter #(.CNT_W(CNT_W)) u_err_cnt (
        .s_CLK(s_CLK), .s_RSTn(s_RSTn), .inc(push & i_flag[FLAG_ERR]), .clr(i_clr_cnt), .cnt(o_err_cnt)
    );
    alu_sat_counter #(.CNT_W(CNT_W)) u_ovf_cnt (
        .s_CLK(s_CLK), .s_RSTn(s_RSTn), .inc(push & i_flag[FLAG_OVERFLOW]), .clr(i_clr_cnt), .cnt(o_ovf_cnt)
    );
endmodule

// File: tb/tb_alu_result_buffer.sv
// tb_alu_result_buffer: scoreboard bench for the ALU result buffer (default and 2-bit counter builds)
module tb_alu_result_buffer;
    localparam int DEPTH = 4;
    logic       s_CLK = 1'b0, s_RSTn = 1'b1;
    logic       i_valid = 1'b0, i_ready = 1'b0, i_clr_cnt = 1'b0;
    logic [3:0] i_result = '0, i_flag = '0;
    logic       o_in_ready, o_valid, o_drop;
    logic [3:0] o_data, o_dflag;
    logic [2:0] o_count;
    logic [7:0] o_err_cnt, o_ovf_cnt;
    logic       o_in_ready2, o_valid2, o_drop2;
    logic [3:0] o_data2, o_dflag2;
    logic [2:0] o_count2;
    logic [1:0] o_err_cnt2, o_ovf_cnt2;
    logic [7:0] q[$];
    int         n_err = 0, n_ovf = 0, total = 0, bad = 0;
    logic       m_drop = 1'b0;

    always #5 s_CLK = ~s_CLK;

    alu_result_buffer dut (
        .s_CLK(s_CLK), .s_RSTn(s_RSTn), .i_valid(i_valid), .i_result(i_result), .i_flag(i_flag),
        .o_in_ready(o_in_ready), .o_valid(o_valid), .i_ready(i_ready), .o_data(o_data), .o_dflag(o_dflag),
        .o_count(o_count), .i_clr_cnt(i_clr_cnt), .o_err_cnt(o_err_cnt), .o_ovf_cnt(o_ovf_cnt), .o_drop(o_drop)
    );

    alu_result_buffer #(.CNT_W(2)) dut2 (
        .s_CLK(s_CLK), .s_RSTn(s_RSTn), .i_valid(i_valid), .i_result(i_result), .i_flag(i_flag),
        .o_in_ready(o_in_ready2), .o_valid(o_valid2), .i_ready(i_ready), .o_data(o_data2), .o_dflag(o_dflag2),
        .o_count(o_count2), .i_clr_cnt(i_clr_cnt), .o_err_cnt(o_err_cnt2), .o_ovf_cnt(o_ovf_cnt2), .o_drop(o_drop2)
    );

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, act, exp, $time);
        end
    endtask

    function automatic int sat(input int v, input int mx);
        return v > mx ? mx : v;
    endfunction

    task automatic step(input logic v, input logic [3:0] r, input logic [3:0] f, input logic rdy, input logic clr);
        logic was_full, push, pop;
        i_valid = v; i_result = r; i_flag = f; i_ready = rdy; i_clr_cnt = clr;
        @(negedge s_CLK);
        chk("count", o_count, q.size());
        chk("in_ready", o_in_ready, q.size() != DEPTH);
        chk("valid", o_valid, q.size() != 0);
        chk("data", o_data, q.size() != 0 ? {28'b0, q[0][7:4]} : 32'b0);
        chk("dflag", o_dflag, q.size() != 0 ? {28'b0, q[0][3:0]} : 32'b0);
        chk("err_cnt", o_err_cnt, sat(n_err, 255));
        chk("ovf_cnt", o_ovf_cnt, sat(n_ovf, 255));
        chk("drop", o_drop, m_drop);
        chk("err_cnt2", o_err_cnt2, sat(n_err, 3));
        chk("ovf_cnt2", o_ovf_cnt2, sat(n_ovf, 3));
        chk("count2", o_count2, q.size());
        was_full = q.size() == DEPTH;
        push = v && !was_full;
        pop = rdy && q.size() != 0;
        if (pop) void'(q.pop_front());
        if (push) q.push_back({r, f});
        if (clr) begin
            n_err = 0; n_ovf = 0; m_drop = 1'b0;
        end else begin
            if (push && f[0]) n_err++;
            if (push && f[3]) n_ovf++;
            if (v && was_full) m_drop = 1'b1;
        end
        @(posedge s_CLK);
        #1;
    endtask

    initial begin
        repeat (2) @(posedge s_CLK);
        @(negedge s_CLK);
        s_RSTn = 1'b0;
        @(posedge s_CLK);
        #1;
        step(0, 0, 0, 0, 0);
        step(1, 4'h2, 4'b0100, 0, 0);
        step(0, 0, 0, 0, 0);
        step(0, 0, 0, 1, 0);
        step(0, 0, 0, 1, 0);
        for (int i = 1; i <= 5; i++) step(1, 4'(i), 4'b0000, 0, 0);
        step(0, 0, 0, 0, 0);
        for (int i = 0; i < 5; i++) step(0, 0, 0, 1, 0);
        step(1, 4'hA, 4'b0010, 0, 0);
        for (int i = 0; i < 20; i++) step(1, 4'(i), 4'b0100, 1, 0);
        for (int i = 0; i < 2; i++) step(0, 0, 0, 1, 0);
        step(1, 4'h5, 4'b0001, 1, 0);
        step(1, 4'h6, 4'b1001, 1, 0);
        step(1, 4'h7, 4'b1000, 1, 0);
        step(0, 0, 0, 0, 0);
        step(1, 4'h8, 4'b0001, 0, 1);
        step(0, 0, 0, 1, 0);
        for (int i = 0; i < 5; i++) step(1, 4'(i + 3), 4'b1001, 1, 0);
        step(0, 0, 0, 1, 0);
        for (int i = 0; i < 40; i++)
            step($urandom_range(0, 1), 4'($urandom), 4'($urandom), $urandom_range(0, 1), $urandom_range(0, 15) == 0);
        step(0, 0, 0, 0, 1);
        step(1, 4'hC, 4'b0001, 0, 0);
        step(1, 4'hD, 4'b1000, 0, 0);
        i_valid = 1'b0;
        #2;
        s_RSTn = 1'b1;
        #1;
        chk("rst_valid", o_valid, 0);
        chk("rst_count", o_count, 0);
        chk("rst_in_ready", o_in_ready, 1);
        chk("rst_err", o_err_cnt, 0);
        q.delete();
        n_err = 0; n_ovf = 0; m_drop = 1'b0;
        @(negedge s_CLK);
        s_RSTn = 1'b0;
        @(posedge s_CLK);
        #1;
        step(0, 0, 0, 0, 0);
        step(1, 4'h9, 4'b1100, 0, 0);
        step(0, 0, 0, 1, 0);
        step(0, 0, 0, 0, 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/alu_result_buffer.md
Name: alu_result_buffer

Overview:
- Downstream stage of the ALU top level (WIDTH-bit result plus 4-bit flag vector).
- Captures each valid ALU result/flag pair into a show-ahead FIFO and presents it to the consumer over a valid/ready handshake.
- Keeps saturating statistics counters for the ERR and OVERFLOW flags.
- Raises a sticky drop indicator when a result arrives while the buffer is full.

Parameters:
- WIDTH, 4, ALU result width; matches ALU WIDTH.
- NFLAG, 4, flag vector width; fixed by the flag package.
- DEPTH, 4, FIFO entries; power of two, >=2.
- CNT_W, 8, width of the statistics counters.

Ports:
- s_CLK  in  1  clock; all state updates on rising edge.
- s_RSTn  in  1  reset, asynchronous, active-high.
- i_valid  in  1  ALU result valid this cycle.
- i_result  in  WIDTH  ALU result.
- i_flag  in  NFLAG  ALU flags; bit0 ERR, bit1 NEG, bit2 POS, bit3 OVERFLOW.
- o_in_ready  out  1  buffer can accept; equals not-full.
- o_valid  out  1  head entry valid; equals not-empty.
- i_ready  in  1  consumer accepts head entry.
- o_data  out  WIDTH  head entry result.
- o_dflag  out  NFLAG  head entry flags.
- o_count  out  $clog2(DEPTH)+1  current occupancy.
- i_clr_cnt  in  1  synchronous clear of statistics and drop flag.
- o_err_cnt  out  CNT_W  accepted entries with ERR set.
- o_ovf_cnt  out  CNT_W  accepted entries with OVERFLOW set.
- o_drop  out  1  sticky: at least one result lost.

Behaviour:
- Reset (s_RSTn=1, async): pointers=0, o_count=0, o_valid=0, o_in_ready=1, o_data=0, o_dflag=0, o_err_cnt=0, o_ovf_cnt=0, o_drop=0. Memory contents need not be reset, but o_data/o_dflag are forced to 0 while empty.
- Push = i_valid & ~full: write {i_result,i_flag} at wr_ptr, wr_ptr++ (wraps mod DEPTH).
- Pop = o_valid & i_ready: rd_ptr++ (wraps mod DEPTH).
- Latency: an entry pushed at edge N is visible on o_valid/o_data after edge N, i.e. in cycle N+1. No combinational path from i_valid to o_valid.
- Simultaneous push and pop when not full and not empty: both occur and o_count is unchanged.
- Pop on empty is ignored (o_valid=0).
- i_valid while full: entry dropped and o_drop set to 1. A simultaneous pop still happens, so o_count decrements. The dropped entry does not touch the statistics.
- o_in_ready = (o_count != DEPTH). It is registered-derived and does not depend on i_ready.
- Statistics: on each push, o_err_cnt increments if i_flag[ERR] and o_ovf_cnt increments if i_flag[OVERFLOW]. Both saturate at 2^CNT_W-1 with no wrap.
- i_clr_cnt=1: counters and o_drop go to 0 at the next edge. Clear has priority over increment/set in the same cycle. FIFO contents are not affected.
- Reset mid-stream: all stored entries are discarded immediately (o_valid=0 asynchronously). Counters are cleared.
- o_count is exact at all times, range 0..DEPTH.

Decomposition:
- Package alu_pkg:
  - Flag index constants FLAG_ERR=0, FLAG_NEG=1, FLAG_POS=2, FLAG_OVERFLOW=3.
  - NFLAG=4.
  - Opcode constants OP_SUB=2'b00, OP_NAND=2'b01, OP_STARTING_ONES=2'b10, OP_DECODE=2'b11, shared with the ALU and benches.
- Sub-module alu_sat_counter (params CNT_W): inc, clr, async reset, saturating output. Instantiated twice (ERR, OVERFLOW).
- FIFO storage and pointers stay inline.

Test Plan:
- Reset then single push {4'h2, 4'b0100} with i_ready=0 -> o_valid=1 next cycle, o_data=2, o_dflag=4'b0100, o_count=1. Pulse i_ready -> o_valid=0, o_count=0.
- Push 4 entries (1,2,3,4) with i_ready=0 -> o_count=4, o_in_ready=0. Push 5th -> o_drop=1, o_count stays 4. Drain with i_ready=1 -> outputs 1,2,3,4 in order, then o_valid=0.
- Steady stream with i_valid=i_ready=1 for 20 cycles after one preload -> o_count constant at 1, data emerges in order with 1-cycle latency, pointers wrap past DEPTH without loss.
- Push 3 entries with flags 4'b0001, 4'b1001, 4'b1000 -> o_err_cnt=2, o_ovf_cnt=2. Assert i_clr_cnt alongside a push of 4'b0001 -> both counters=0 and o_drop=0 at the next edge.
- With CNT_W=2, push 5 entries with ERR set (draining as needed) -> o_err_cnt saturates at 3.
- Fill 2 entries, assert s_RSTn mid-cycle -> o_valid=0 and o_count=0 immediately. After release, a new push is read back correctly.
